// File: rtl/ibuf_pkg.sv
// Shared definitions for the input-buffer loader: default data width, geometry
// derivation functions used by both the address generator and the fill controller,
// and the fill FSM state type.
package ibuf_pkg;

   localparam int unsigned DW_DEF = 16;

   typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} fill_state_e;

   // Pixels kept per fetched row.
   function automatic int unsigned calc_bufw(input int unsigned pox, input int unsigned stride,
                                             input int unsigned ksize);
      return pox * stride + ksize / 2;
   endfunction

   // Input rows per block.
   function automatic int unsigned calc_lm(input int unsigned stride, input int unsigned poy);
      return (stride + 1) * poy - stride;
   endfunction

   // Beats fetched per row: whole bursts covering bufw, padding included.
   function automatic int unsigned calc_rbeats(input int unsigned bufw, input int unsigned burst);
      return (bufw / burst + 1) * burst;
   endfunction

endpackage

// File: rtl/ibuf_bank_flags.sv
// Per-bank "block valid" flags for the ping-pong line buffer. A set from the fill
// side always wins over a same-cycle release of the same bank; releasing a bank that
// is not valid (or is being set) is reported as a protocol error.
module ibuf_bank_flags (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] set_req,
   input  logic [1:0] rel_req,
   output logic [1:0] ready,
   output logic [1:0] ready_next,
   output logic       rel_err
);

   logic [1:0] ready_q;

   // Next flag value and release error detection.
   always_comb begin
      ready_next = (ready_q & ~rel_req) | set_req;
      rel_err    = |(rel_req & (~ready_q | set_req));
   end

   // Flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 2'b00;
      end else begin
         ready_q <= ready_next;
      end
   end

   assign ready = ready_q;

endmodule

// File: rtl/ibuf_fill_ctrl.sv
// Read-data side of the input-buffer loader. Accepts read beats, keeps the first
// BUFW pixels of each RBEATS-beat row, writes them into the current ping-pong bank
// and hands full blocks of LM rows to the PE array via the bank flags.
module ibuf_fill_ctrl
   import ibuf_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned KSIZE   = 3,
   parameter int unsigned POX     = 16,
   parameter int unsigned POY     = 3,
   parameter int unsigned STRIDE  = 2,
   parameter int unsigned BURST   = 32,
   localparam int unsigned BUFW   = calc_bufw(POX, STRIDE, KSIZE),
   localparam int unsigned LM     = calc_lm(STRIDE, POY),
   localparam int unsigned RBEATS = calc_rbeats(BUFW, BURST),
   localparam int unsigned CW     = $clog2(RBEATS),
   localparam int unsigned RW     = (LM > 1) ? $clog2(LM) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          blk_start,
   input  logic [DW-1:0] rdata,
   input  logic          rvalid,
   input  logic          rlast,
   output logic          rready,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [RW-1:0] wr_row,
   output logic [5:0]    wr_col,
   output logic [DW-1:0] wr_data,
   output logic          row_done,
   output logic [1:0]    blk_ready,
   input  logic [1:0]    blk_release,
   output logic          err
);

   fill_state_e   state_q, state_d;
   logic [CW-1:0] bc_q, bc_d;
   logic [RW-1:0] row_q, row_d;
   logic          bank_q, bank_d;
   logic          err_q, err_d;

   logic          wr_en_q, wr_bank_q, row_done_q;
   logic [RW-1:0] wr_row_q;
   logic [5:0]    wr_col_q;
   logic [DW-1:0] wr_data_q;

   logic          accept, row_end, blk_end, burst_edge;
   logic          start_err, rlast_err, rel_err;
   logic [1:0]    set_req, ready_next;

   assign rready     = (state_q == FILL);
   assign accept     = rvalid & rready;
   assign row_end    = accept && (bc_q == CW'(RBEATS - 1));
   assign blk_end    = row_end && (row_q == RW'(LM - 1));
   // rlast is only checked, never used to realign the counters.
   assign burst_edge = ((32'(bc_q) + 32'd1) % BURST) == 32'd0;
   assign rlast_err  = accept && (rlast != burst_edge);
   assign start_err  = blk_start && (state_q != IDLE);
   assign set_req    = blk_end ? (bank_q ? 2'b10 : 2'b01) : 2'b00;

   ibuf_bank_flags u_flags (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_req    (set_req),
      .rel_req    (blk_release),
      .ready      (blk_ready),
      .ready_next (ready_next),
      .rel_err    (rel_err)
   );

   // FSM next state; a completed block waits if the new fill bank is still held.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (blk_start) state_d = FILL;
         FILL:      if (blk_end) state_d = ready_next[~bank_q] ? WAIT_BANK : IDLE;
         WAIT_BANK: if (!ready_next[bank_q]) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Beat/row counters, fill bank and sticky error next state.
   always_comb begin
      bc_d   = bc_q;
      row_d  = row_q;
      bank_d = bank_q;
      if (accept) begin
         bc_d = row_end ? '0 : bc_q + CW'(1);
         if (row_end) row_d = blk_end ? '0 : row_q + RW'(1);
         if (blk_end) bank_d = ~bank_q;
      end
      err_d = err_q | start_err | rlast_err | rel_err;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bc_q    <= '0;
         row_q   <= '0;
         bank_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bc_q    <= bc_d;
         row_q   <= row_d;
         bank_q  <= bank_d;
         err_q   <= err_d;
      end
   end

   // One-cycle write path into the line buffer; padding beats produce no strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q    <= 1'b0;
         row_done_q <= 1'b0;
         wr_bank_q  <= 1'b0;
         wr_row_q   <= '0;
         wr_col_q   <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q    <= accept && (bc_q < CW'(BUFW));
         row_done_q <= row_end;
         if (accept) begin
            wr_bank_q <= bank_q;
            wr_row_q  <= row_q;
            wr_col_q  <= 6'(bc_q);
            wr_data_q <= rdata;
         end
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_bank  = wr_bank_q;
   assign wr_row   = wr_row_q;
   assign wr_col   = wr_col_q;
   assign wr_data  = wr_data_q;
   assign row_done = row_done_q;
   assign err      = err_q;

endmodule

// File: doc/ibuf_fill_ctrl.md
Name: ibuf_fill_ctrl

Overview:
- Read-data side of the input-buffer loader. It consumes the memory read-data channel (rdata/rvalid/rlast) that answers bursts issued by the input-buffer address generator.
- It keeps the first BUFW pixels of every fetched row and discards the burst padding. Kept pixels go into one of two ping-pong line-buffer banks, LM rows per block.
- It hands completed blocks to the PE array through a ready/release handshake and back-pressures memory when both banks are full.

Parameters:
DW, 16, pixel/beat data width (one pixel per beat)
KSIZE, 3, kernel size
POX, 16, output columns per block
POY, 3, output rows per block
STRIDE, 2, convolution stride
BURST, 32, beats per read burst
(derived localparams, not overridable) BUFW = POX*STRIDE+KSIZE/2 = 33; LM = (STRIDE+1)*POY-STRIDE = 7; NB = BUFW/BURST+1 = 2 bursts per row; RBEATS = NB*BURST = 64; CW = clog2(RBEATS); RW = clog2(LM)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
blk_start  in  1  pulse: a new block fetch begins (same cycle the address generator receives init_addr_en/result_valid)
rdata  in  DW  read beat data
rvalid  in  1  read beat valid
rlast  in  1  last beat of burst
rready  out  1  read beat accept
wr_en  out  1  line-buffer write strobe
wr_bank  out  1  target bank
wr_row  out  RW  row within block, 0..LM-1
wr_col  out  6  column, 0..BUFW-1
wr_data  out  DW  pixel
row_done  out  1  pulse: row fully received
blk_ready  out  2  per-bank "block valid" flags
blk_release  in  2  per-bank release pulse from the PE array
err  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync deassert handled outside the block): state IDLE; all counters 0; wr_bank=0; blk_ready=0; err=0; rready=0; wr_en=0; row_done=0.
- States:
  - IDLE: rready=0. blk_start -> FILL.
  - FILL: rready=1.
  - WAIT_BANK: rready=0; the fill bank is the other bank, which is still held by the PE array. Release of that bank -> IDLE.
- Beat accept: rvalid&rready.
- Write path (1-cycle latency): a beat accepted at cycle t with beat counter bc<BUFW drives wr_en=1 at t+1 with wr_col=bc, wr_row=row counter, wr_bank=fill bank, wr_data=rdata. A beat with bc>=BUFW is dropped (wr_en=0).
- Beat counter bc (CW bits): increments per accepted beat. An accepted beat with bc==RBEATS-1 wraps bc to 0, increments the row counter, and pulses row_done at t+1.
- Block completion: an accepted beat with bc==RBEATS-1 and row==LM-1 does all of the following:
  - sets blk_ready[fill bank] at t+1;
  - clears row to 0 and toggles the fill bank;
  - next state is IDLE if blk_ready[new bank]==0 after the same-cycle release, else WAIT_BANK.
- rlast check: rlast must coincide with an accepted beat whose (bc+1) mod BURST == 0. rlast at any other beat sets err. Any such beat (bc at a burst boundary) without rlast also sets err. Counting is never corrected by rlast.
- blk_release[i]: clears blk_ready[i] next cycle.
  - Release of a bank whose flag is 0 sets err and is otherwise ignored.
  - Release and set of the same bank in the same cycle: set wins. Release is ignored and err is set.
  - Release of one bank and set of the other in the same cycle are both applied.
- blk_start outside IDLE: ignored, err set. blk_start in IDLE with rvalid high in the same cycle: the beat is not accepted (rready=0 that cycle).
- rvalid while rready=0: no state change (the beat is held by the master).
- err clears only on reset.
- Reset mid-row: partial row discarded, blk_ready flags cleared, fill bank returns to 0.

Decomposition:
- Shared package ibuf_pkg: DW default; derivation functions for BUFW, LM, RBEATS (shared with the address generator so both agree); state enum type fill_state_e {IDLE, FILL, WAIT_BANK}.
- One natural sub-module: ibuf_bank_flags. It holds the two blk_ready flags, the set/release arbitration and the release-error detection.
- Beat/row counters and the FSM stay in the top.

Test Plan:
1. Reset, blk_start, 7 rows x 64 beats with rvalid=1 and rlast every 32nd beat -> 231 wr_en pulses (33 per row, cols 0..32), 7 row_done pulses, blk_ready=2'b01 after the final beat, state IDLE, err=0.
2. Second block without release, then a third blk_start -> second block fills bank 1, blk_ready=2'b11, state WAIT_BANK, rready=0, third blk_start sets err=1. blk_release=2'b01 -> blk_ready=2'b10, state IDLE.
3. rlast asserted at beat 20 of a row -> err=1 at the next cycle; bc continues to 21; the row still completes at beat 63.
4. rvalid toggled every other cycle over one row -> wr_col strictly 0..32 with no gaps; row_done exactly once, one cycle after the 64th accepted beat.
5. blk_release[0] in the same cycle bank 1 completes, with blk_ready=2'b01 beforehand -> blk_ready=2'b10, next state IDLE, err=0.
6. rst_n asserted at beat 40 of row 3 -> all outputs at reset values immediately. A new blk_start writes to bank 0, row 0, col 0.
